// File: rtl/display_pkg.sv
// Shared constants for the display arbiter: FSM encodings, segment codes and the
// dwell-length helper.
package display_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StDwell = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int unsigned dwell_cycles(input int unsigned freq, input int unsigned ms);
    int unsigned cycles;
    cycles = (freq / 1000) * ms;
    return (cycles == 0) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Single hex nibble to active-low seven-segment code.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing the 8-digit display between four requesters; each grant
// is held for a minimum dwell time before the next pending request is served.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned SOURCE_FREQ = 100000000,
  parameter int unsigned DWELL_MS    = 500
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  req_i,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [31:0] data3_i,
  input  logic [3:0]  exp_i,
  output logic [3:0]  ack_o,
  output logic [1:0]  grant_id_o,
  output logic        busy_o,
  output logic        shown_o,
  output logic [6:0]  seg0_o,
  output logic [6:0]  seg1_o,
  output logic [6:0]  seg2_o,
  output logic [6:0]  seg3_o,
  output logic [6:0]  seg4_o,
  output logic [6:0]  seg5_o,
  output logic [6:0]  seg6_o,
  output logic [6:0]  seg7_o,
  output logic        exp_flag_o
);

  localparam int unsigned DwellCycles = dwell_cycles(SOURCE_FREQ, DWELL_MS);
  localparam logic [31:0] DwellLast   = DwellCycles - 32'd1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic             exp_q, exp_d;
  logic             shown_q, shown_d;
  logic [1:0]       winner;
  logic             found;
  logic [1:0]       idx;
  logic [3:0][31:0] data_all;
  logic             granted;

  assign data_all = {data3_i, data2_i, data1_i, data0_i};
  assign granted  = (state_q == StGrant) && req_i[grant_q];

  // Scan last+1, last+2, ... so the most recently served requester goes last.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    exp_d   = exp_q;
    shown_d = shown_q;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (req_i[grant_q]) begin
          word_d  = data_all[grant_q];
          exp_d   = exp_i[grant_q];
          shown_d = 1'b1;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = StDwell;
        end else begin
          state_d = StIdle;
        end
      end
      StDwell: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == DwellLast) begin
          if (|req_i) begin
            grant_d = winner;
            state_d = StGrant;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      word_q  <= '0;
      exp_q   <= 1'b0;
      shown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      exp_q   <= exp_d;
      shown_q <= shown_d;
    end
  end

  logic [7:0][6:0] seg_enc;
  logic [7:0][6:0] seg_out;

  // Blank until the first word is latched so the reset value of word_q never shows.
  for (genvar i = 0; i < 8; i++) begin : g_digit
    hex_to_7seg u_hex (
      .hex_i (word_q[4*i +: 4]),
      .seg_o (seg_enc[i])
    );
    assign seg_out[i] = shown_q ? seg_enc[i] : SEG_BLANK;
  end

  assign ack_o      = granted ? (4'b0001 << grant_q) : 4'b0000;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StGrant) || (state_q == StDwell);
  assign shown_o    = shown_q;
  assign exp_flag_o = shown_q & exp_q;
  assign seg0_o     = seg_out[0];
  assign seg1_o     = seg_out[1];
  assign seg2_o     = seg_out[2];
  assign seg3_o     = seg_out[3];
  assign seg4_o     = seg_out[4];
  assign seg5_o     = seg_out[5];
  assign seg6_o     = seg_out[6];
  assign seg7_o     = seg_out[7];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a transaction-level model predicts each ack
// (who, when, what data) and a monitor checks acks and the resulting display.
module tb_display_arbiter;

  localparam int unsigned FREQ = 1000;
  localparam int unsigned MS   = 4;
  localparam int          DC   = 4;
  localparam logic [6:0]  BLANK = 7'b1111111;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'b0;
  logic [3:0]       exp_in = 4'b0;
  logic [3:0][31:0] data_v = '0;
  logic [3:0]       ack;
  logic [1:0]       grant_id;
  logic             busy, shown, exp_flag;
  logic [6:0]       seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [55:0]      segs_all;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t cur;
  logic seg_chk = 1'b0;
  logic [55:0] disp_exp = {8{7'b1111111}};
  int   ack_log[$];
  int   ack_clog[$];
  int   ack_cyc[4] = '{-10, -10, -10, -10};
  bit   model_en = 1'b1;
  int   m_last = 3;
  int   next_decide = 0;

  display_arbiter #(
    .SOURCE_FREQ (FREQ),
    .DWELL_MS    (MS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .data0_i    (data_v[0]),
    .data1_i    (data_v[1]),
    .data2_i    (data_v[2]),
    .data3_i    (data_v[3]),
    .exp_i      (exp_in),
    .ack_o      (ack),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .shown_o    (shown),
    .seg0_o     (seg0),
    .seg1_o     (seg1),
    .seg2_o     (seg2),
    .seg3_o     (seg3),
    .seg4_o     (seg4),
    .seg5_o     (seg5),
    .seg6_o     (seg6),
    .seg7_o     (seg7),
    .exp_flag_o (exp_flag)
  );

  assign segs_all = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] hex_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [55:0] enc_word(input logic [31:0] d);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = hex_ref(d[i*4 +: 4]);
    return r;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference model: once the arbiter is free (DC cycles after the last ack, or idle),
  // the first cycle with any request decides, and the ack follows one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_last      = 3;
      next_decide = 0;
    end else if (model_en && cyc >= next_decide && req != 4'b0) begin
      int w;
      w = pick(req, m_last);
      sb.push_back('{id: w, d: data_v[w], e: exp_in[w], cyc: cyc + 1});
      m_last      = w;
      next_decide = cyc + 1 + DC;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      seg_chk  = 1'b0;
      disp_exp = {8{BLANK}};
    end else begin
      if (seg_chk) begin
        check("sb_segs", segs_all, enc_word(cur.d));
        check("sb_exp_flag", exp_flag, cur.e);
        check("sb_shown", shown, 1);
        disp_exp = enc_word(cur.d);
        seg_chk  = 1'b0;
      end
      if (ack != 4'b0) begin
        ack_log.push_back(int'(ack));
        ack_clog.push_back(cyc);
        for (int i = 0; i < 4; i++) if (ack[i]) ack_cyc[i] = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_ack: got ack=%b, expected no ack", ack);
        end else begin
          cur = sb.pop_front();
          check("sb_ack", ack, 4'b0001 << cur.id);
          check("sb_ack_cycle", cyc, cur.cyc);
          check("sb_grant_id", grant_id, cur.id);
          seg_chk = 1'b1;
        end
      end
    end
  end

  // Requesters drop their request the cycle after being acked.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (ack_cyc[i] == cyc - 1) req[i] = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cycles);
    int n;
    n = 0;
    while ((req != 4'b0 || busy) && n < max_cycles) begin
      tick();
      n++;
    end
    if (req != 4'b0 || busy) begin
      tests++;
      fails++;
      $display("FAIL wait_quiet: still busy=%b req=%b after %0d cycles, expected idle",
               busy, req, max_cycles);
    end
  endtask

  initial begin
    int s;
    logic [55:0] prev;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_segs", segs_all, {8{BLANK}});
    check("rst_exp_flag", exp_flag, 0);
    check("rst_shown", shown, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_grant_id", grant_id, 0);

    // Round-robin from the reset pointer.
    for (int i = 0; i < 4; i++) data_v[i] = $urandom;
    exp_in = 4'($urandom);
    s = ack_log.size();
    req = 4'hF;
    wait_quiet(200);
    check("rr_count", ack_log.size() - s, 4);
    if (ack_log.size() >= s + 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", ack_log[s + i], 1 << i);
      for (int i = 0; i < 3; i++) check("rr_spacing", ack_clog[s + i + 1] - ack_clog[s + i], DC + 1);
    end

    // Single request with known word.
    data_v[0] = 32'h0123ABCD;
    exp_in[0] = 1'b1;
    req = 4'b0001;
    tick();
    check("single_ack", ack, 4'b0001);
    check("single_busy", busy, 1);
    tick();
    check("single_seg0", seg0, 7'b0100001);
    check("single_seg7", seg7, 7'b1000000);
    check("single_exp_flag", exp_flag, 1);
    repeat (3) tick();
    check("single_dwell_busy", busy, 1);
    tick();
    check("single_idle", busy, 0);

    // Fairness: after serving 2, requester 0 comes before 2.
    data_v[2] = $urandom;
    req = 4'b0100;
    wait_quiet(50);
    data_v[0] = $urandom;
    data_v[2] = $urandom;
    s = ack_log.size();
    req = 4'b0101;
    wait_quiet(50);
    check("fair_count", ack_log.size() - s, 2);
    if (ack_log.size() >= s + 2) begin
      check("fair_first", ack_log[s], 4'b0001);
      check("fair_second", ack_log[s + 1], 4'b0100);
    end

    // Abandoned grant: request vanishes before the ack.
    model_en = 1'b0;
    prev = disp_exp;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    #1;
    check("abandon_busy", busy, 1);
    check("abandon_ack", ack, 0);
    tick();
    check("abandon_idle", busy, 0);
    check("abandon_segs", segs_all, prev);
    model_en = 1'b1;

    // Reset in the middle of a dwell.
    data_v[1] = 32'hFFFFFFFF;
    exp_in[1] = 1'b1;
    req = 4'b0010;
    tick();
    tick();
    check("ff_segs", segs_all, {8{7'b0001110}});
    rst_n = 1'b0;
    #1;
    check("midrst_segs", segs_all, {8{BLANK}});
    check("midrst_shown", shown, 0);
    check("midrst_busy", busy, 0);
    check("midrst_exp_flag", exp_flag, 0);
    tick();
    rst_n = 1'b1;
    data_v[3] = $urandom;
    s = ack_log.size();
    req = 4'b1000;
    wait_quiet(50);
    check("midrst_next_count", ack_log.size() - s, 1);
    if (ack_log.size() > s) check("midrst_next_ack", ack_log[s], 4'b1000);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 7) == 0) begin
          data_v[i] = $urandom;
          exp_in[i] = 1'($urandom_range(0, 1));
          req[i]    = 1'b1;
        end
      end
      tick();
    end
    wait_quiet(200);
    tick();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
